s_ram_arbiter: RTL



---
 rtl/ksa_pkg.sv | 20 ++
 rtl/s_ram_arbiter_rr_pick.sv | 29 ++
 rtl/s_ram_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/ksa_pkg.sv
// Shared constants and types for the S-array RAM arbiter and its requesters.
package ksa_pkg;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;

   localparam int REQ_INIT = 0;
   localparam int REQ_KSA  = 1;
   localparam int REQ_PRGA = 2;

   typedef enum logic {
      ARB  = 1'b0,
      HOLD = 1'b1
   } arb_state_t;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/s_ram_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick, scanning upward from ptr_i+1 with wrap.
module rr_pick #(
   parameter int N_REQ = 3,
   parameter int IDX_W = 2
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N_REQ-1:0] win_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             any_o
);

   always_comb begin
      int k;
      // NOTE: every output gets a default before the scan so no latch is inferred.
      win_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      for (int i = 1; i <= N_REQ; i++) begin
         k = (int'(ptr_i) + i) % N_REQ;
         if (!any_o && req_i[k]) begin
            any_o    = 1'b1;
            win_o[k] = 1'b1;
            idx_o    = IDX_W'(k);
         end
      end
   end

endmodule

// File: rtl/s_ram_arbiter.sv
// s_ram_arbiter: round-robin arbiter with ownership lock for the single-port S-array RAM.
// Optional forced release of an idle lock: define LOCK_TIMEOUT_EN.
module s_ram_arbiter
   import ksa_pkg::*;
#(
   parameter int N_REQ    = 3,
   parameter int LOCK_MAX = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ-1:0]        lock,
   input  logic [N_REQ-1:0]        wr,
   input  logic [N_REQ*ADDR_W-1:0] addr,
   input  logic [N_REQ*DATA_W-1:0] wdata,
   output logic [N_REQ-1:0]        gnt,
   output logic [N_REQ-1:0]        rvalid,
   output logic [DATA_W-1:0]       rdata,
   output logic [N_REQ-1:0]        lock_err,
   output logic [ADDR_W-1:0]       ram_address,
   output logic [DATA_W-1:0]       ram_data,
   output logic                    ram_wren,
   input  logic [DATA_W-1:0]       ram_q
);

   localparam int               IDX_W    = idx_width(N_REQ);
   localparam logic [IDX_W-1:0] PTR_INIT = IDX_W'(N_REQ - 1);

   arb_state_t        state_q;
   logic [IDX_W-1:0]  ptr_q;
   logic [IDX_W-1:0]  owner_q;
   logic [N_REQ-1:0]  rd_pend_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;

   logic [N_REQ-1:0]  pick_oh;
   logic [IDX_W-1:0]  pick_idx;
   logic              pick_any;
   logic [IDX_W-1:0]  gidx;
   logic              gvalid;
   logic              lock_take;
   logic              force_rel;

   rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req_i (req),
      .ptr_i (ptr_q),
      .win_o (pick_oh),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   // In HOLD only the owner can be granted; everyone else stalls.
   always_comb begin
      gnt    = '0;
      gidx   = pick_idx;
      gvalid = 1'b0;
      if (!reset) begin
         if (state_q == ARB) begin
            gnt    = pick_oh;
            gvalid = pick_any;
         end else begin
            gidx          = owner_q;
            gvalid        = req[owner_q];
            gnt[owner_q]  = req[owner_q];
         end
      end
   end

   assign ram_address = gvalid ? addr[gidx*ADDR_W +: ADDR_W]  : addr_q;
   assign ram_data    = gvalid ? wdata[gidx*DATA_W +: DATA_W] : data_q;
   assign ram_wren    = gvalid & wr[gidx];
   assign rvalid      = reset ? '0 : rd_pend_q;
   assign rdata       = ram_q;

`ifdef LOCK_TIMEOUT_EN
   localparam int CNT_W = $clog2(LOCK_MAX + 1);

   logic [CNT_W-1:0] idle_cnt_q;
   logic             ign_q;
   logic [IDX_W-1:0] ign_idx_q;

   assign force_rel = !reset && (state_q == HOLD) && lock[owner_q] && !req[owner_q]
                      && (idle_cnt_q == CNT_W'(LOCK_MAX - 1));
   // A requester whose lock was forced off must drop lock once before it can lock again.
   assign lock_take = lock[gidx] && !(ign_q && (ign_idx_q == gidx));

   always_comb begin
      lock_err          = '0;
      lock_err[owner_q] = force_rel;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idle_cnt_q <= '0;
         ign_q      <= 1'b0;
         ign_idx_q  <= '0;
      end else begin
         if ((state_q == HOLD) && !req[owner_q] && !force_rel) begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
         end else begin
            idle_cnt_q <= '0;
         end
         if (force_rel) begin
            ign_q     <= 1'b1;
            ign_idx_q <= owner_q;
         end else if (!lock[ign_idx_q]) begin
            ign_q <= 1'b0;
         end
      end
   end
`else
   localparam int lock_max_unused = LOCK_MAX;

   assign force_rel = 1'b0;
   assign lock_take = lock[gidx];
   assign lock_err  = '0;
`endif

   // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ARB;
         ptr_q     <= PTR_INIT;
         owner_q   <= '0;
         rd_pend_q <= '0;
         addr_q    <= '0;
         data_q    <= '0;
      end else begin
         rd_pend_q <= (gvalid && !wr[gidx]) ? gnt : '0;
         addr_q    <= ram_address;
         data_q    <= ram_data;
         case (state_q)
            ARB: begin
               if (gvalid) begin
                  ptr_q <= gidx;
                  if (lock_take) begin
                     owner_q <= gidx;
                     state_q <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (!lock[owner_q] || force_rel) begin
                  state_q <= ARB;
               end
            end
            default: state_q <= ARB;
         endcase
      end
   end

endmodule
